// File: rtl/shifter_stage_pkg.sv
// Shared definitions for the operand-2 stage: shift types, FSM states,
// data-processing opcodes and the record held while waiting for Rs.
package shifter_stage_pkg;

  typedef enum logic [1:0] {
    SHIFT_LSL = 2'b00,
    SHIFT_LSR = 2'b01,
    SHIFT_ASR = 2'b10,
    SHIFT_ROR = 2'b11
  } shift_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RS   = 1'b1
  } state_t;

  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_EOR = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_ADC = 4'h5;
  localparam logic [3:0] OP_SBC = 4'h6;
  localparam logic [3:0] OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8;
  localparam logic [3:0] OP_TEQ = 4'h9;
  localparam logic [3:0] OP_CMP = 4'hA;
  localparam logic [3:0] OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC;
  localparam logic [3:0] OP_MOV = 4'hD;
  localparam logic [3:0] OP_BIC = 4'hE;
  localparam logic [3:0] OP_MVN = 4'hF;

  // Logical ops take their C flag from the shifter carry-out.
  function automatic logic isLogicalOp(input logic [3:0] op);
    case (op)
      OP_AND, OP_EOR, OP_TST, OP_TEQ,
      OP_ORR, OP_MOV, OP_BIC, OP_MVN: isLogicalOp = 1'b1;
      default:                        isLogicalOp = 1'b0;
    endcase
  endfunction

  typedef struct packed {
    logic [3:0]  opcode;
    logic [31:0] rn;
    logic [31:0] rm;
    logic        c;
    shift_t      shType;
  } pending_t;

endpackage

// File: rtl/shifter_stage_if.sv
// Decode-to-stage offer, Rs value and stage-to-ALU operand handshake.
interface shifter_stage_if;

  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_opcode;
  logic        in_imm;
  logic [11:0] in_shop;
  logic [31:0] in_rn;
  logic [31:0] in_rm;
  logic        in_c;
  logic [31:0] rs_val;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic        out_shc;
  logic        out_c;

  modport master (
    output in_valid, in_opcode, in_imm, in_shop, in_rn, in_rm, in_c, rs_val, out_ready,
    input  in_ready, out_valid, out_opcode, out_a, out_b, out_shc, out_c
  );

  modport slave (
    input  in_valid, in_opcode, in_imm, in_shop, in_rn, in_rm, in_c, rs_val, out_ready,
    output in_ready, out_valid, out_opcode, out_a, out_b, out_shc, out_c
  );

endinterface

// File: rtl/shifter_stage_barrel_shift.sv
// Combinational ARM barrel shifter using register-form amount semantics;
// the caller folds immediate #0 encodings into amount 32 or rrx.
module barrel_shift
  import shifter_stage_pkg::*;
(
  input  logic [31:0] value_i,
  input  shift_t      shType_i,
  input  logic [7:0]  amount_i,
  input  logic        rrx_i,
  input  logic        c_i,
  output logic [31:0] result_o,
  output logic        c_o
);

  logic [4:0]  amtLo;
  logic [4:0]  lslIdx;
  logic [4:0]  rightIdx;
  logic [31:0] asrVal;
  logic [31:0] rorVal;

  assign amtLo    = amount_i[4:0];
  assign lslIdx   = 5'd0 - amtLo;
  assign rightIdx = amtLo - 5'd1;
  assign asrVal   = $signed(value_i) >>> amtLo;
  // Left part uses 32-amt wrapped to 5 bits; only meaningful when amtLo != 0.
  assign rorVal   = (value_i >> amtLo) | (value_i << lslIdx);

  always_comb begin
    result_o = value_i;
    c_o      = c_i;
    if (rrx_i) begin
      result_o = {c_i, value_i[31:1]};
      c_o      = value_i[0];
    end else if (amount_i != 8'd0) begin
      unique case (shType_i)
        SHIFT_LSL: begin
          if (amount_i < 8'd32) begin
            result_o = value_i << amtLo;
            c_o      = value_i[lslIdx];
          end else if (amount_i == 8'd32) begin
            result_o = 32'h0;
            c_o      = value_i[0];
          end else begin
            result_o = 32'h0;
            c_o      = 1'b0;
          end
        end
        SHIFT_LSR: begin
          if (amount_i < 8'd32) begin
            result_o = value_i >> amtLo;
            c_o      = value_i[rightIdx];
          end else if (amount_i == 8'd32) begin
            result_o = 32'h0;
            c_o      = value_i[31];
          end else begin
            result_o = 32'h0;
            c_o      = 1'b0;
          end
        end
        SHIFT_ASR: begin
          if (amount_i < 8'd32) begin
            result_o = asrVal;
            c_o      = value_i[rightIdx];
          end else begin
            result_o = {32{value_i[31]}};
            c_o      = value_i[31];
          end
        end
        SHIFT_ROR: begin
          if (amtLo == 5'd0) begin
            result_o = value_i;
            c_o      = value_i[31];
          end else begin
            result_o = rorVal;
            c_o      = value_i[rightIdx];
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/shifter_stage.sv
// Operand-2 stage: decodes the shifter operand, waits one cycle for Rs on
// register-shifted forms, and holds ALU operands in a valid/ready register.
module shifter_stage
  import shifter_stage_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  shifter_stage_if.slave bus
);

  state_t      state_q, state_d;
  pending_t    pend_q, pend_d;
  logic        outValid_q, outValid_d;
  logic [3:0]  outOpcode_q, outOpcode_d;
  logic [31:0] outA_q, outA_d;
  logic [31:0] outB_q, outB_d;
  logic        outShc_q, outShc_d;
  logic        outC_q, outC_d;

  logic        accept;
  logic        isRegReg;
  logic        load;
  logic [4:0]  immN;
  logic        unusedBits;

  logic [3:0]  srcOpcode;
  logic [31:0] srcRn;
  logic        srcC;
  shift_t      srcType;
  logic [31:0] shValue;
  shift_t      shType;
  logic [7:0]  shAmount;
  logic        shRrx;
  logic [31:0] shResult;
  logic        shCout;

  assign bus.in_ready = (state_q == ST_IDLE) && (!outValid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready && !flush;
  assign isRegReg     = !bus.in_imm && bus.in_shop[4];
  assign immN         = bus.in_shop[11:7];
  assign unusedBits   = ^{bus.in_shop[3:0], bus.rs_val[31:8]};

  // In RS the shifter works on the latched op; otherwise on the live offer.
  always_comb begin
    srcOpcode = bus.in_opcode;
    srcRn     = bus.in_rn;
    srcC      = bus.in_c;
    srcType   = shift_t'(bus.in_shop[6:5]);
    shValue   = bus.in_rm;
    shType    = srcType;
    shAmount  = {3'b000, immN};
    shRrx     = 1'b0;
    if (state_q == ST_RS) begin
      srcOpcode = pend_q.opcode;
      srcRn     = pend_q.rn;
      srcC      = pend_q.c;
      srcType   = pend_q.shType;
      shValue   = pend_q.rm;
      shType    = pend_q.shType;
      shAmount  = bus.rs_val[7:0];
    end else if (bus.in_imm) begin
      shValue  = {24'h0, bus.in_shop[7:0]};
      shType   = SHIFT_ROR;
      shAmount = {3'b000, bus.in_shop[11:8], 1'b0};
    end else if (immN == 5'd0) begin
      shAmount = (srcType == SHIFT_LSL) ? 8'd0 : 8'd32;
      shRrx    = (srcType == SHIFT_ROR);
    end
  end

  barrel_shift u_barrel (
    .value_i  (shValue),
    .shType_i (shType),
    .amount_i (shAmount),
    .rrx_i    (shRrx),
    .c_i      (srcC),
    .result_o (shResult),
    .c_o      (shCout)
  );

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    load    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (isRegReg) begin
            pend_d.opcode = bus.in_opcode;
            pend_d.rn     = bus.in_rn;
            pend_d.rm     = bus.in_rm;
            pend_d.c      = bus.in_c;
            pend_d.shType = srcType;
            state_d       = ST_RS;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_RS: begin
        state_d = ST_IDLE;
        load    = 1'b1;
      end
    endcase
    if (flush) begin
      state_d = ST_IDLE;
      load    = 1'b0;
    end
  end

  // A load in the consume cycle overwrites the register with no bubble.
  always_comb begin
    outValid_d  = outValid_q && !bus.out_ready;
    outOpcode_d = outOpcode_q;
    outA_d      = outA_q;
    outB_d      = outB_q;
    outShc_d    = outShc_q;
    outC_d      = outC_q;
    if (load) begin
      outValid_d  = 1'b1;
      outOpcode_d = srcOpcode;
      outA_d      = srcRn;
      outB_d      = shResult;
      outShc_d    = shCout;
      outC_d      = srcC;
    end
    if (flush) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      outValid_q  <= 1'b0;
      outOpcode_q <= 4'h0;
      outA_q      <= 32'h0;
      outB_q      <= 32'h0;
      outShc_q    <= 1'b0;
      outC_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      outValid_q  <= outValid_d;
      outOpcode_q <= outOpcode_d;
      outA_q      <= outA_d;
      outB_q      <= outB_d;
      outShc_q    <= outShc_d;
      outC_q      <= outC_d;
    end
  end

  assign bus.out_valid  = outValid_q;
  assign bus.out_opcode = outOpcode_q;
  assign bus.out_a      = outA_q;
  assign bus.out_b      = outB_q;
  assign bus.out_shc    = outShc_q;
  assign bus.out_c      = outC_q;

endmodule

// File: tb/tb_shifter_stage.sv
// Bench for shifter_stage: constant vector table, latency/backpressure/flush/
// reset sequences, and a randomized run checked through a scoreboard queue.
module tb_shifter_stage;
  import shifter_stage_pkg::*;

  typedef struct {
    logic        imm;
    logic [11:0] shop;
    logic [31:0] rm;
    logic [31:0] rn;
    logic        c;
    logic [7:0]  rs;
    logic [3:0]  opcode;
    logic [31:0] expB;
    logic        expShc;
  } vec_t;

  typedef struct {
    logic [3:0]  opcode;
    logic [31:0] a;
    logic [31:0] b;
    logic        shc;
    logic        c;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  logic readyForce;
  logic randReady;
  logic randBit = 1'b1;
  int   checks = 0;
  int   failures = 0;
  exp_t expQ[$];
  vec_t tbl[15];

  logic        prevHeld = 1'b0;
  logic [71:0] prevSnap = '0;
  logic [71:0] snap;
  exp_t        popped;

  always #5 clk = ~clk;

  shifter_stage_if bus();

  shifter_stage dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus)
  );

  assign bus.out_ready = readyForce | (randReady & randBit);
  assign snap = {1'b0, bus.out_valid, bus.out_opcode, bus.out_a, bus.out_b, bus.out_shc, bus.out_c};

  always @(posedge clk) begin
    #1;
    randBit = 1'($urandom_range(0, 1));
  end

  task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Independent reference: wide shifts and bit loops straight from the ARM rules.
  function automatic logic [32:0] modelShift(input logic imm, input logic [11:0] shop,
                                             input logic [31:0] rm, input logic c, input logic [7:0] rs);
    logic [31:0] b;
    logic [31:0] v;
    logic [63:0] t;
    int s;
    int r;
    if (imm) begin
      v = {24'h0, shop[7:0]};
      r = 2 * shop[11:8];
      for (int i = 0; i < 32; i++) b[i] = v[(i + r) % 32];
      return {((r == 0) ? c : b[31]), b};
    end
    if (!shop[4]) begin
      s = shop[11:7];
      if (s == 0) begin
        if (shop[6:5] == 2'b01 || shop[6:5] == 2'b10) s = 32;
        if (shop[6:5] == 2'b11) return {rm[0], c, rm[31:1]};
      end
    end else begin
      s = rs;
    end
    if (s == 0) return {c, rm};
    case (shop[6:5])
      2'b00: begin t = {32'h0, rm} << s; return {t[32], t[31:0]}; end
      2'b01: begin t = {rm, 32'h0} >> s; return {t[31], t[63:32]}; end
      2'b10: begin t = $signed({rm, 32'h0}) >>> s; return {t[31], t[63:32]}; end
      default: begin
        r = s % 32;
        if (r == 0) return {rm[31], rm};
        for (int i = 0; i < 32; i++) b[i] = rm[(i + r) % 32];
        return {b[31], b};
      end
    endcase
  endfunction

  function automatic vec_t mk(input logic imm, input logic [11:0] shop, input logic [31:0] rm,
                              input logic [31:0] rn, input logic c, input logic [7:0] rs,
                              input logic [3:0] op, input logic [31:0] expB, input logic expShc);
    vec_t v;
    v.imm = imm; v.shop = shop; v.rm = rm; v.rn = rn; v.c = c; v.rs = rs;
    v.opcode = op; v.expB = expB; v.expShc = expShc;
    return v;
  endfunction

  function automatic exp_t expOf(input vec_t v);
    exp_t e;
    e.opcode = v.opcode; e.a = v.rn; e.b = v.expB; e.shc = v.expShc; e.c = v.c;
    return e;
  endfunction

  function automatic logic isRegReg(input vec_t v);
    return !v.imm && v.shop[4];
  endfunction

  // Rs is driven wrong during the accept cycle and right in the following one.
  task automatic driveOp(input vec_t v);
    bus.in_opcode = v.opcode;
    bus.in_imm    = v.imm;
    bus.in_shop   = v.shop;
    bus.in_rn     = v.rn;
    bus.in_rm     = v.rm;
    bus.in_c      = v.c;
    bus.rs_val    = ~{24'hDEAD5A, v.rs};
  endtask

  task automatic applyStimulus(input vec_t v);
    int waited = 0;
    driveOp(v);
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checkOutput("accept_timeout", {71'b0, bus.in_ready}, 72'd1);
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      return;
    end
    expQ.push_back(expOf(v));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.rs_val   = {24'hDEAD5A, v.rs};
    if (isRegReg(v)) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (expQ.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain", 72'(expQ.size()), 72'd0);
    @(posedge clk); #1;
  endtask

  // Scoreboard and hold-stability monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      prevHeld = 1'b0;
    end else begin
      if (prevHeld) checkOutput("hold_stable", snap, prevSnap);
      if (bus.out_valid && bus.out_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_output", {71'b0, bus.out_valid}, 72'd0);
        end else begin
          popped = expQ.pop_front();
          checkOutput("out_opcode", 72'(bus.out_opcode), 72'(popped.opcode));
          checkOutput("out_a", 72'(bus.out_a), 72'(popped.a));
          checkOutput("out_b", 72'(bus.out_b), 72'(popped.b));
          checkOutput("out_shc", 72'(bus.out_shc), 72'(popped.shc));
          checkOutput("out_c", 72'(bus.out_c), 72'(popped.c));
        end
      end
      prevHeld = bus.out_valid && !bus.out_ready && !flush;
      prevSnap = snap;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t v;
    logic [32:0] m;
    int k;

    tbl[0]  = mk(1'b1, 12'h4FF, 32'h00000000, 32'h11111111, 1'b0, 8'd0,  OP_MOV, 32'hFF000000, 1'b1);
    tbl[1]  = mk(1'b0, 12'h020, 32'h80000001, 32'h22222222, 1'b0, 8'd0,  OP_AND, 32'h00000000, 1'b1);
    tbl[2]  = mk(1'b0, 12'h060, 32'h00000003, 32'h33333333, 1'b1, 8'd0,  OP_ORR, 32'h80000001, 1'b1);
    tbl[3]  = mk(1'b0, 12'h010, 32'hFFFFFFFF, 32'h44444444, 1'b1, 8'd33, OP_EOR, 32'h00000000, 1'b0);
    tbl[4]  = mk(1'b0, 12'h050, 32'h80000000, 32'h55555555, 1'b0, 8'd40, OP_BIC, 32'hFFFFFFFF, 1'b1);
    tbl[5]  = mk(1'b0, 12'h070, 32'h80000000, 32'h66666666, 1'b0, 8'd32, OP_MVN, 32'h80000000, 1'b1);
    tbl[6]  = mk(1'b0, 12'h200, 32'h12345678, 32'h77777777, 1'b0, 8'd0,  OP_ADD, 32'h23456780, 1'b1);
    tbl[7]  = mk(1'b1, 12'h0AB, 32'h00000000, 32'h88888888, 1'b1, 8'd0,  OP_SUB, 32'h000000AB, 1'b1);
    tbl[8]  = mk(1'b0, 12'h010, 32'h00000001, 32'h99999999, 1'b0, 8'd32, OP_TST, 32'h00000000, 1'b1);
    tbl[9]  = mk(1'b0, 12'h030, 32'h00001234, 32'hAAAAAAAA, 1'b1, 8'd0,  OP_CMP, 32'h00001234, 1'b1);
    tbl[10] = mk(1'b0, 12'h0C0, 32'h80000003, 32'hBBBBBBBB, 1'b0, 8'd0,  OP_TEQ, 32'hC0000001, 1'b1);
    tbl[11] = mk(1'b0, 12'h070, 32'h0000000F, 32'hCCCCCCCC, 1'b0, 8'd4,  OP_RSB, 32'hF0000000, 1'b1);
    tbl[12] = mk(1'b0, 12'h420, 32'h0000FF80, 32'hDDDDDDDD, 1'b0, 8'd0,  OP_ADC, 32'h000000FF, 1'b1);
    tbl[13] = mk(1'b1, 12'h101, 32'h00000000, 32'hEEEEEEEE, 1'b1, 8'd0,  OP_CMN, 32'h40000000, 1'b0);
    tbl[14] = mk(1'b0, 12'h030, 32'hFFFFFFFF, 32'h0F0F0F0F, 1'b1, 8'd33, OP_SBC, 32'h00000000, 1'b0);

    rst = 1'b1; flush = 1'b0; readyForce = 1'b1; randReady = 1'b0;
    bus.in_valid = 1'b0; bus.in_opcode = 4'h0; bus.in_imm = 1'b0; bus.in_shop = 12'h0;
    bus.in_rn = 32'h0; bus.in_rm = 32'h0; bus.in_c = 1'b0; bus.rs_val = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    @(negedge clk);
    checkOutput("reset_out_valid", 72'(bus.out_valid), 72'd0);
    checkOutput("reset_out_b", 72'(bus.out_b), 72'd0);
    checkOutput("reset_out_a", 72'(bus.out_a), 72'd0);
    checkOutput("reset_in_ready", 72'(bus.in_ready), 72'd1);
    @(posedge clk); #1;

    // Immediate form: result one cycle after accept.
    driveOp(tbl[0]);
    bus.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("imm_in_ready", 72'(bus.in_ready), 72'd1);
    expQ.push_back(expOf(tbl[0]));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("imm_latency", 72'(bus.out_valid), 72'd1);
    @(posedge clk); #1;

    // Register-by-register: in_ready low in RS, result two cycles after accept.
    driveOp(tbl[3]);
    bus.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("rr_in_ready", 72'(bus.in_ready), 72'd1);
    expQ.push_back(expOf(tbl[3]));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.rs_val = {24'hDEAD5A, tbl[3].rs};
    @(negedge clk);
    checkOutput("rr_no_early_valid", 72'(bus.out_valid), 72'd0);
    checkOutput("rr_in_ready_low", 72'(bus.in_ready), 72'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rr_latency", 72'(bus.out_valid), 72'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) applyStimulus(tbl[i]);
    waitDrain();

    // Backpressure: held output stays put, then release accepts in the consume cycle.
    readyForce = 1'b0;
    applyStimulus(tbl[7]);
    driveOp(tbl[6]);
    bus.in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 72'(bus.out_valid), 72'd1);
      checkOutput("bp_in_ready_low", 72'(bus.in_ready), 72'd0);
      checkOutput("bp_out_b", 72'(bus.out_b), 72'(tbl[7].expB));
    end
    @(posedge clk); #1;
    readyForce = 1'b1;
    @(negedge clk);
    checkOutput("release_in_ready", 72'(bus.in_ready), 72'd1);
    expQ.push_back(expOf(tbl[6]));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("release_next_valid", 72'(bus.out_valid), 72'd1);
    checkOutput("release_next_b", 72'(bus.out_b), 72'(tbl[6].expB));
    waitDrain();

    // Flush in RS together with a new offer.
    driveOp(tbl[4]);
    bus.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("flush_rr_accept", 72'(bus.in_ready), 72'd1);
    @(posedge clk); #1;
    bus.rs_val = {24'hDEAD5A, tbl[4].rs};
    flush = 1'b1;
    driveOp(tbl[0]);
    bus.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("flush_rs_in_ready", 72'(bus.in_ready), 72'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_kill", 72'(bus.out_valid), 72'd0);
    checkOutput("flush_idle", 72'(bus.in_ready), 72'd1);
    @(posedge clk); #1;
    flush = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("flush_beats_valid", 72'(bus.out_valid), 72'd0);
    @(posedge clk); #1;
    applyStimulus(tbl[1]);
    waitDrain();

    // Reset mid-RS clears everything; accept resumes right after.
    driveOp(tbl[5]);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    driveOp(tbl[6]);
    bus.in_valid = 1'b1;
    @(negedge clk);
    checkOutput("rst_outputs_zero", snap, 72'd0);
    checkOutput("rst_in_ready", 72'(bus.in_ready), 72'd1);
    expQ.push_back(expOf(tbl[6]));
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checkOutput("rst_resume", 72'(bus.out_valid), 72'd1);
    @(posedge clk); #1;
    waitDrain();

    // Randomized ops under random backpressure, expected values from the model.
    readyForce = 1'b0;
    randReady  = 1'b1;
    for (int i = 0; i < 60; i++) begin
      v.imm    = 1'($urandom_range(0, 1));
      v.shop   = 12'($urandom);
      if (!v.imm && v.shop[4]) v.shop[7] = 1'b0;
      v.rm     = ($urandom_range(0, 3) == 0) ? 32'h80000001 : $urandom;
      v.rn     = $urandom;
      v.c      = 1'($urandom_range(0, 1));
      v.opcode = 4'($urandom);
      k = $urandom_range(0, 5);
      case (k)
        0: v.rs = 8'd0;
        1: v.rs = 8'd1;
        2: v.rs = 8'd31;
        3: v.rs = 8'd32;
        4: v.rs = 8'd33;
        default: v.rs = 8'($urandom);
      endcase
      m = modelShift(v.imm, v.shop, v.rm, v.c, v.rs);
      v.expB   = m[31:0];
      v.expShc = m[32];
      applyStimulus(v);
    end
    readyForce = 1'b1;
    waitDrain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
